// File: rtl/sample_acquisition_az.sv
// Precharge/auto-zero acquisition sequencer: BOOT, SETTLE, HI, PC_RESTORE, LO, END phases.
// Define SAMPLE_ACQ_MONITOR_EN to drive the debug monitor bus; otherwise it is tied to zero.
module sample_acquisition_az #(
  parameter int AZMUX_W = 4,
  parameter int PC_W    = 24,
  parameter int DUR_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               run,
  input  logic [AZMUX_W-1:0] azmux_hi_val,
  input  logic [AZMUX_W-1:0] azmux_lo_val,
  input  logic [PC_W-1:0]    clk_count_precharge_n,
  input  logic [DUR_W-1:0]   clk_sample_duration,
  output logic               sw_pc_ctl,
  output logic [AZMUX_W-1:0] azmux,
  output logic               sample_valid,
  output logic               sample_is_hi,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               busy,
  output logic               led0,
  output logic [7:0]         monitor
);

  localparam int CW = (PC_W > DUR_W) ? PC_W : DUR_W;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOOT       = 3'd1,
    S_SETTLE     = 3'd2,
    S_HI         = 3'd3,
    S_PC_RESTORE = 3'd4,
    S_LO         = 3'd5,
    S_END        = 3'd6
  } state_t;

  state_t             state, nxt_state;
  logic [CW-1:0]      cnt, nxt_cnt;
  logic [1:0]         mode_l, nxt_mode;
  logic [PC_W-1:0]    pc_l, nxt_pc;
  logic [DUR_W-1:0]   dur_l, nxt_dur;
  logic               nxt_valid, nxt_sw;
  logic [AZMUX_W-1:0] nxt_az;

  // The counter holds remaining clocks minus one, so a zero length still yields one clock.
  function automatic logic [CW-1:0] load_pc(input logic [PC_W-1:0] n);
    return (n == '0) ? '0 : CW'(n) - CW'(1);
  endfunction

  function automatic logic [CW-1:0] load_dur(input logic [DUR_W-1:0] n);
    return (n == '0) ? '0 : CW'(n) - CW'(1);
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_mode  = mode_l;
    nxt_pc    = pc_l;
    nxt_dur   = dur_l;
    case (state)
      S_IDLE, S_END: begin
        if (run && mode != 2'd0) begin
          nxt_mode  = mode;
          nxt_pc    = clk_count_precharge_n;
          nxt_dur   = clk_sample_duration;
          nxt_state = (state == S_IDLE) ? S_BOOT : S_SETTLE;
          nxt_cnt   = load_pc(clk_count_precharge_n);
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_BOOT, S_SETTLE, S_HI, S_PC_RESTORE, S_LO: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - CW'(1);
        end else begin
          case (state)
            S_BOOT:   begin nxt_state = S_SETTLE;     nxt_cnt = load_pc(pc_l);   end
            S_SETTLE: begin nxt_state = S_HI;         nxt_cnt = load_dur(dur_l); end
            S_HI:     begin nxt_state = S_PC_RESTORE; nxt_cnt = load_pc(pc_l);   end
            S_PC_RESTORE: begin
              if (mode_l == 2'd3) begin
                nxt_state = S_END;
              end else begin
                nxt_state = S_LO;
                nxt_cnt   = load_dur(dur_l);
              end
            end
            default:  nxt_state = S_END;
          endcase
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are derived from the state being entered so they register on the entry edge.
  always_comb begin
    nxt_valid = (nxt_state == S_HI || nxt_state == S_LO) && (nxt_cnt == '0);
    nxt_sw    = (nxt_state == S_HI);
    case (nxt_state)
      S_SETTLE, S_HI, S_PC_RESTORE: nxt_az = (nxt_mode == 2'd1) ? azmux_lo_val : azmux_hi_val;
      S_END:                        nxt_az = (nxt_mode == 2'd3) ? azmux_hi_val : azmux_lo_val;
      default:                      nxt_az = azmux_lo_val;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mode_l       <= '0;
      pc_l         <= '0;
      dur_l        <= '0;
      sw_pc_ctl    <= 1'b0;
      azmux        <= '0;
      sample_valid <= 1'b0;
      sample_is_hi <= 1'b0;
      cycle_count  <= '0;
      busy         <= 1'b0;
      led0         <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      mode_l       <= nxt_mode;
      pc_l         <= nxt_pc;
      dur_l        <= nxt_dur;
      sw_pc_ctl    <= nxt_sw;
      azmux        <= nxt_az;
      sample_valid <= nxt_valid;
      sample_is_hi <= nxt_valid && (nxt_state == S_HI);
      busy         <= (nxt_state != S_IDLE);
      led0         <= nxt_sw;
      if (nxt_state == S_END) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

`ifdef SAMPLE_ACQ_MONITOR_EN
  logic [7:0] monitor_r;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) monitor_r <= 8'h00;
    else       monitor_r <= {3'b000, nxt_sw, nxt_valid, nxt_state};
  end
  assign monitor = monitor_r;
`else
  assign monitor = 8'h00;
`endif

endmodule

// File: tb/tb_sample_acquisition_az.sv
// Bench for sample_acquisition_az: table vectors, randomized runs against a phase-list model,
// and a mid-LO reset sequence.
module tb_sample_acquisition_az;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        run;
  logic [3:0]  azmux_hi_val, azmux_lo_val;
  logic [23:0] clk_count_precharge_n;
  logic [31:0] clk_sample_duration;
  logic        sw_pc_ctl, sample_valid, sample_is_hi, busy, led0;
  logic [3:0]  azmux;
  logic [15:0] cycle_count;
  logic [7:0]  monitor;

  sample_acquisition_az dut (
    .clk(clk), .reset(reset), .mode(mode), .run(run),
    .azmux_hi_val(azmux_hi_val), .azmux_lo_val(azmux_lo_val),
    .clk_count_precharge_n(clk_count_precharge_n), .clk_sample_duration(clk_sample_duration),
    .sw_pc_ctl(sw_pc_ctl), .azmux(azmux), .sample_valid(sample_valid),
    .sample_is_hi(sample_is_hi), .cycle_count(cycle_count), .busy(busy),
    .led0(led0), .monitor(monitor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cc = '0;

  typedef struct {
    logic       sw;
    logic [3:0] az;
    logic       valid;
    logic       ishi;
    logic       led;
    logic       bsy;
    logic       is_end;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int m, p, s, h, l, d;
    int exp_busy, exp_strobes, exp_ends;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic sw, input logic [3:0] az, input logic valid, input logic ishi,
                      input logic bsy, input logic is_end);
    exp_t e;
    e.sw = sw; e.az = az; e.valid = valid; e.ishi = ishi; e.led = sw; e.bsy = bsy; e.is_end = is_end;
    q.push_back(e);
  endtask

  // Expected per-clock outputs, clock 0 being the first clock after run is seen in IDLE.
  // Run is sampled at the end of clock t as (t < d).
  task automatic build_model(input int m, input int p, input int s, input logic [3:0] h,
                             input logic [3:0] l, input int d);
    int pp, sp, te;
    logic [3:0] mid_az;
    pp = (p == 0) ? 1 : p;
    sp = (s == 0) ? 1 : s;
    mid_az = (m == 1) ? l : h;
    q.delete();
    if (m != 0) begin
      for (int i = 0; i < pp; i++) push(1'b0, l, 1'b0, 1'b0, 1'b1, 1'b0);
      do begin
        for (int i = 0; i < pp; i++) push(1'b0, mid_az, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < sp; i++) push(1'b1, mid_az, i == sp - 1, i == sp - 1, 1'b1, 1'b0);
        for (int i = 0; i < pp; i++) push(1'b0, mid_az, 1'b0, 1'b0, 1'b1, 1'b0);
        if (m != 3)
          for (int i = 0; i < sp; i++) push(1'b0, l, i == sp - 1, 1'b0, 1'b1, 1'b0);
        push(1'b0, (m == 3) ? h : l, 1'b0, 1'b0, 1'b1, 1'b1);
        te = q.size() - 1;
      end while (te < d);
    end
    for (int i = 0; i < 3; i++) push(1'b0, l, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at a negedge with the DUT in IDLE.
  task automatic play(input int m, input int p, input int s, input int h, input int l, input int d,
                      output int nbusy, output int nstrobe, output int nend);
    nbusy = 0; nstrobe = 0; nend = 0;
    mode = 2'(m);
    clk_count_precharge_n = 24'(p);
    clk_sample_duration = 32'(s);
    azmux_hi_val = 4'(h);
    azmux_lo_val = 4'(l);
    run = 1'b1;
    build_model(m, p, s, 4'(h), 4'(l), d);
    @(posedge clk);
    for (int t = 0; t < q.size(); t++) begin
      @(negedge clk);
      run = (t < d);
      if (q[t].is_end) exp_cc++;
      check("outputs{sw,az,valid,is_hi,led,busy}",
            {sw_pc_ctl, azmux, sample_valid, sample_is_hi, led0, busy},
            {q[t].sw, q[t].az, q[t].valid, q[t].ishi, q[t].led, q[t].bsy});
      check("cycle_count", cycle_count, exp_cc);
`ifdef SAMPLE_ACQ_MONITOR_EN
      check("monitor", {monitor[7:3], monitor[2:0] != 3'd0}, {3'b000, sw_pc_ctl, sample_valid, busy});
`else
      check("monitor", monitor, 8'h00);
`endif
      nbusy += busy;
      nstrobe += sample_valid;
      if (q[t].is_end) nend++;
    end
  endtask

  initial begin
    int nb, ns, ne;
    vt[0] = '{2, 3, 5, 4'hA, 4'h3, 24, 37, 4, 2};
    vt[1] = '{3, 2, 4, 4'h5, 4'hC, 23, 29, 3, 3};
    vt[2] = '{1, 2, 2, 4'h9, 4'h6, 14, 20, 4, 2};
    vt[3] = '{2, 0, 0, 4'hF, 4'h1, 12, 16, 6, 3};
    vt[4] = '{0, 4, 4, 4'h2, 4'h7, 5, 0, 0, 0};

    reset = 1'b1; run = 1'b0; mode = 2'd2;
    azmux_hi_val = 4'hA; azmux_lo_val = 4'h5;
    clk_count_precharge_n = 24'd3; clk_sample_duration = 32'd5;
    #12;
    check("reset_outputs", {sw_pc_ctl, azmux, sample_valid, sample_is_hi, led0, busy},
          {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_cycle_count", cycle_count, 16'd0);
    check("reset_monitor", monitor, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_idle_azmux", azmux, 4'h5);
    check("first_idle_busy", busy, 1'b0);

    for (int v = 0; v < 5; v++) begin
      play(vt[v].m, vt[v].p, vt[v].s, vt[v].h, vt[v].l, vt[v].d, nb, ns, ne);
      check($sformatf("vec%0d_busy_clocks", v), nb, vt[v].exp_busy);
      check($sformatf("vec%0d_strobes", v), ns, vt[v].exp_strobes);
      check($sformatf("vec%0d_cycles", v), ne, vt[v].exp_ends);
    end

    for (int r = 0; r < 10; r++) begin
      int m, p, s, k, h, l, pp, sp, per, d;
      m = $urandom_range(1, 3);
      p = $urandom_range(0, 4);
      s = $urandom_range(0, 5);
      k = $urandom_range(1, 3);
      h = $urandom_range(0, 15);
      l = h ^ (1 + $urandom_range(0, 14));
      pp = (p == 0) ? 1 : p;
      sp = (s == 0) ? 1 : s;
      per = (m == 3) ? (2 * pp + sp + 1) : (2 * pp + 2 * sp + 1);
      d = pp + (k - 1) * per + pp + 1;
      play(m, p, s, h, l, d, nb, ns, ne);
      check($sformatf("rand%0d_busy_clocks", r), nb, pp + k * per);
      check($sformatf("rand%0d_strobes", r), ns, k * ((m == 3) ? 1 : 2));
      check($sformatf("rand%0d_cycles", r), ne, k);
    end

    // Reset asserted in the middle of the LO phase (mode 2, P=3, S=5: LO spans clocks 14..18).
    mode = 2'd2; clk_count_precharge_n = 24'd3; clk_sample_duration = 32'd5;
    azmux_hi_val = 4'hC; azmux_lo_val = 4'h2; run = 1'b1;
    @(posedge clk);
    repeat (16) @(negedge clk);
    check("mid_lo_azmux", azmux, 4'h2);
    check("mid_lo_busy", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outputs", {sw_pc_ctl, azmux, sample_valid, sample_is_hi, led0, busy},
          {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("async_reset_cycle_count", cycle_count, 16'd0);
    check("async_reset_monitor", monitor, 8'h00);
    repeat (2) begin
      @(negedge clk);
      check("reset_held_valid", sample_valid, 1'b0);
      check("reset_held_busy", busy, 1'b0);
    end
    run = 1'b0;
    reset = 1'b0;
    exp_cc = '0;
    @(negedge clk);
    check("post_reset_azmux", azmux, 4'h2);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_cycle_count", cycle_count, exp_cc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
